// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle RV32 subset (R/lw/sw/beq) control sequencer with memory-ready handshake and retire counter.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OpCode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       Aluop,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Illegal
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMREAD = 4'd4, MEMWB = 4'd5,
    MEMWRITE = 4'd6, EXECUTE = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, TRAP = 4'd10
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_q, load_d, retire;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif
  assign State      = state_q;
  assign InstrCount = cnt_q;
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        // memory ops remember load vs store so MEMADR never re-reads OpCode
        load_d = OpCode == OP_LW;
        case (OpCode)
          OP_R:         state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = TRAP;
            illegal_d = 1'b1;
`else
            state_d = FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      MEMADR:   state_d = load_q ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: begin
        state_d = MemReady ? FETCH : MEMWRITE;
        retire  = MemReady;
      end
      EXECUTE:  state_d = ALUWB;
      MEMWB, ALUWB, BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:     state_d = TRAP;
      default:  state_d = IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    AluSrcA  = 1'b0;
    AluSrcB  = 2'b00;
    Aluop    = 2'b00;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:   AluSrcB = 2'b11;
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        AluSrcA = 1'b1;
        Aluop   = 2'b10;
      end
      ALUWB:    RegWrite = 1'b1;
      BRANCH: begin
        AluSrcA = 1'b1;
        Aluop   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random and directed instruction streams checked against a per-instruction path model.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4, S_MEMWB = 5;
  localparam int S_MEMWRITE = 6, S_EXECUTE = 7, S_ALUWB = 8, S_BRANCH = 9, S_TRAP = 10;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] OpCode = '0;
  logic Zero = 1'b0, MemReady = 1'b0;
  logic PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, AluSrcA, Illegal;
  logic [1:0] AluSrcB, Aluop;
  logic [3:0] State;
  logic [CNT_W-1:0] InstrCount;
  logic [12:0] ctl;
  int checks = 0, errors = 0, cnt = 0;
  logic ill = 1'b0;
  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .Aluop(Aluop), .State(State), .InstrCount(InstrCount), .Illegal(Illegal)
  );
  assign ctl = {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, AluSrcA, AluSrcB, Aluop};
  always #5 clk = ~clk;
  function automatic logic [12:0] exp_ctl(input int s, input logic mr, input logic z);
    logic pcw, pcs, iord, irw, mrd, mwr, m2r, rw, asa;
    logic [1:0] asb, aop;
    {pcw, pcs, iord, irw, mrd, mwr, m2r, rw, asa, asb, aop} = '0;
    if (s == S_FETCH) begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
    if (s == S_DECODE) asb = 2'b11;
    if (s == S_MEMADR) begin asa = 1; asb = 2'b10; end
    if (s == S_MEMREAD) begin mrd = 1; iord = 1; end
    if (s == S_MEMWB) begin rw = 1; m2r = 1; end
    if (s == S_MEMWRITE) begin mwr = 1; iord = 1; end
    if (s == S_EXECUTE) begin asa = 1; aop = 2'b10; end
    if (s == S_ALUWB) rw = 1;
    if (s == S_BRANCH) begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
    return {pcw, pcs, iord, irw, mrd, mwr, m2r, rw, asa, asb, aop};
  endfunction
  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input int s, input logic mr, input logic z);
    chk("state", 32'(State), 32'(s));
    chk("controls", 32'(ctl), 32'(exp_ctl(s, mr, z)));
    chk("count", 32'(InstrCount), 32'(cnt));
    chk("illegal", 32'(Illegal), 32'(ill));
    chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
  endtask
  task automatic step(input int s, input logic mr, input logic z, input logic [6:0] op);
    MemReady = mr;
    Zero     = z;
    OpCode   = op;
    #2;
    check_all(s, mr, z);
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic z);
    for (int i = 0; i < fs; i++) step(S_FETCH, 1'b0, rbit(), rop());
    step(S_FETCH, 1'b1, rbit(), rop());
    step(S_DECODE, rbit(), rbit(), op);
    if (op == OP_R) begin
      step(S_EXECUTE, rbit(), rbit(), rop());
      step(S_ALUWB, rbit(), rbit(), rop());
    end else if (op == OP_LW || op == OP_SW) begin
      step(S_MEMADR, rbit(), rbit(), rop());
      for (int i = 0; i < ms; i++) step(op == OP_LW ? S_MEMREAD : S_MEMWRITE, 1'b0, rbit(), rop());
      step(op == OP_LW ? S_MEMREAD : S_MEMWRITE, 1'b1, rbit(), rop());
      if (op == OP_LW) step(S_MEMWB, rbit(), rbit(), rop());
    end else if (op == OP_BEQ) begin
      step(S_BRANCH, rbit(), z, rop());
    end else begin
`ifdef ILLEGAL_TRAP_EN
      ill = 1'b1;
      for (int i = 0; i < 4; i++) step(S_TRAP, rbit(), rbit(), rop());
      return;
`endif
    end
    cnt = (cnt + 1) % (1 << CNT_W);
  endtask
  initial begin
    logic [6:0] ops [5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BAD};
    #2;
    check_all(S_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(S_IDLE, 1'b1, 1'b0, rop());
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 1, 0, 1'b0);
    for (int n = 0; n < 30; n++) begin
`ifdef ILLEGAL_TRAP_EN
      run_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 2), $urandom_range(0, 2), rbit());
`else
      run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2), rbit());
`endif
    end
    if (cnt == 0) run_instr(OP_R, 0, 0, 1'b0);
    step(S_FETCH, 1'b1, 1'b0, rop());
    step(S_DECODE, 1'b0, 1'b0, OP_LW);
    step(S_MEMADR, 1'b0, 1'b0, rop());
    step(S_MEMREAD, 1'b0, 1'b0, rop());
    #2;
    rst_n = 1'b0;
    #1;
    cnt = 0;
    check_all(S_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(S_IDLE, 1'b1, 1'b0, rop());
    for (int n = 0; n < 16; n++) run_instr(OP_R, 0, 0, 1'b0);
    MemReady = 1'b0;
    #2;
    check_all(S_FETCH, 1'b0, Zero);
    run_instr(OP_BAD, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
    MemReady = 1'b0;
    #2;
    check_all(S_FETCH, 1'b0, Zero);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
